// File: rtl/dfd_pkg.sv
// dfd_pkg: shared DFD APB widths and the requester FSM state type
package dfd_pkg;
    localparam int DFD_APB_ADDR_WIDTH  = 23;
    localparam int DFD_APB_DATA_WIDTH  = 32;
    localparam int DFD_APB_PSTRB_WIDTH = DFD_APB_DATA_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} DfdApbReqState_e;
endpackage

// File: rtl/dfd_apb_requester.sv
// dfd_apb_requester: single-command APB requester with misalignment and wait-timeout error reporting
module dfd_apb_requester
    import dfd_pkg::*;
#(
    parameter int ADDR_WIDTH     = DFD_APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DFD_APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);
    DfdApbReqState_e state_q, state_d;
    logic [15:0] wait_cnt;
    logic accept, aligned, at_limit;

    assign accept    = (state_q == IDLE) && req_valid;
    assign aligned   = req_addr[1:0] == 2'b00;
    assign at_limit  = wait_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = state_q == ACCESS;
    assign pprot     = 3'b000;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? (aligned ? SETUP : RESP) : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (pready || at_limit) ? RESP : ACCESS;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && aligned) begin
                pwrite   <= req_write;
                paddr    <= req_addr;
                pwdata   <= req_wdata;
                pstrb    <= req_write ? req_strb : '0;
                wait_cnt <= '0;
            end
            if (accept && !aligned) begin
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= '0;
            end
            // pready has priority over the timeout threshold in the same cycle
            if (state_q == ACCESS) begin
                if (pready) begin
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                end else if (at_limit) begin
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/dfd_apb_requester.md
DFD_APB_REQUESTER -- requirements
Module: dfd_apb_requester

Interface
REQ-001 Parameter ADDR_WIDTH, default DFD_APB_ADDR_WIDTH (23), APB byte-address width.
REQ-002 Parameter DATA_WIDTH, default DFD_APB_DATA_WIDTH (32), APB data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, maximum ACCESS-phase cycles before abort; legal range 2..65535.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  command valid.
REQ-007 req_ready  out  1  command accepted when req_valid && req_ready.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_WIDTH  byte address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 req_strb  in  STRB_WIDTH  write byte strobes.
REQ-012 rsp_valid  out  1  response valid.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
REQ-015 rsp_err  out  1  pslverr, misalignment or timeout.
REQ-016 rsp_timeout  out  1  error caused by timeout.
REQ-017 psel, penable, pwrite  out  1 each  APB control.
REQ-018 paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH; pstrb  out  STRB_WIDTH; pprot  out  3 (constant 3'b000).
REQ-019 prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-021 IDLE + accepted aligned command (req_addr[1:0] == 0): register write, addr, wdata and strb (strb forced to 0 for reads); go to SETUP.
REQ-022 IDLE + accepted misaligned command: no APB activity; go to RESP with rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
REQ-023 SETUP lasts exactly one cycle: psel = 1, penable = 0; go to ACCESS.
REQ-024 ACCESS: psel = 1, penable = 1; paddr, pwrite, pwdata and pstrb hold their SETUP values until exit.
REQ-025 ACCESS with pready = 1: capture rsp_err = pslverr; capture rsp_rdata = prdata only if read and pslverr = 0, otherwise 0; go to RESP.
REQ-026 Wait counter (16 bits): cleared on SETUP entry, incremented each ACCESS cycle with pready = 0.
REQ-027 Counter reaching TIMEOUT_CYCLES-1 with pready = 0: abort to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; psel = 0 from the next cycle.
REQ-028 pready = 1 in the same cycle as the timeout threshold: pready wins and no timeout is flagged.
REQ-029 RESP: rsp_* held stable until rsp_ready; on handshake go to IDLE (one idle cycle minimum between commands).
REQ-030 Outside SETUP/ACCESS: psel = 0 and penable = 0; paddr, pwdata and pstrb keep their last values.
REQ-031 Best-case read latency: accept at cycle 0, SETUP at 1, ACCESS at 2 with pready, rsp_valid at 3.

Reset
REQ-032 reset: state = IDLE; psel, penable, pwrite, rsp_err, rsp_timeout = 0; paddr, pwdata, pstrb, rsp_rdata, counter = 0.
REQ-033 reset mid-transfer: abandon the transfer with no response; psel drops in the cycle after reset is sampled.

Structure
REQ-034 DFD_APB_ADDR_WIDTH, DFD_APB_DATA_WIDTH and DFD_APB_PSTRB_WIDTH come from dfd_pkg; the FSM state enum (DfdApbReqState_e) is added to dfd_pkg.
REQ-035 Single flat module with no sub-modules.

Verification
REQ-036 Write 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, pready = 1 at first ACCESS -> SETUP then ACCESS, one cycle each; rsp_valid at cycle 3, err = 0, rdata = 0.
REQ-037 Read 0x0000_0020, pready after 3 wait cycles, prdata 0x1234_5678 -> paddr held stable throughout; rsp_rdata = 0x1234_5678, err = 0.
REQ-038 Read with TIMEOUT_CYCLES = 4, pready held at 0 -> abort after 4 ACCESS cycles; rsp_err = 1, rsp_timeout = 1, psel = 0 next cycle.
REQ-039 Read 0x0000_0003 -> psel never asserts; rsp_err = 1 one cycle after acceptance.
REQ-040 Read with pslverr = 1 and prdata 0xFFFF_FFFF -> rsp_err = 1, rsp_rdata = 0; rsp held 5 cycles with rsp_ready = 0, and req_ready = 0 during that time.
REQ-041 reset asserted during ACCESS -> all outputs at reset values next cycle; no rsp_valid is produced.
